// File: rtl/sump_pkg.sv
// Shared definitions for the SUMP command decoder.
//   - Opcode constants for every command the decoder recognises.
//   - Assembly FSM state type.
package sump_pkg;

    localparam logic [7:0] OP_RESET  = 8'h00;
    localparam logic [7:0] OP_RUN    = 8'h01;
    localparam logic [7:0] OP_ID     = 8'h02;
    localparam logic [7:0] OP_META   = 8'h04;
    localparam logic [7:0] OP_FINISH = 8'h05;
    localparam logic [7:0] OP_DIV    = 8'h80;
    localparam logic [7:0] OP_CNT    = 8'h81;
    localparam logic [7:0] OP_FLAGS  = 8'h82;
    localparam logic [7:0] OP_TMASK  = 8'hC0;
    localparam logic [7:0] OP_TVAL   = 8'hC1;
    localparam logic [7:0] OP_TCFG   = 8'hC2;

    // Trigger opcodes carry the stage index in bits [4:2]; masking those
    // bits out leaves the base trigger opcode.
    localparam logic [7:0] TRIG_BASE_MASK = 8'hE3;

    typedef enum logic {
        IDLE,
        ARGS
    } state_t;

endpackage

// File: rtl/sump_cmd_strobe.sv
// Registered opcode-to-strobe decoder.
//   clock, reset          : system clock, synchronous active-high reset
//   i_valid, i_opcode     : a complete command with this opcode is ready
//   o_cmd_valid           : one-cycle pulse for any complete command
//   o_sump_* / o_wr_*     : one-cycle pulse for the matching opcode
//   o_wr_trig_*           : one-hot per trigger stage; stages >= NUM_STAGES
//                           produce no bit
module sump_cmd_strobe
    import sump_pkg::*;
#(
    parameter int NUM_STAGES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_valid,
    input  logic [7:0]            i_opcode,
    output logic                  o_cmd_valid,
    output logic                  o_sump_reset,
    output logic                  o_sump_run,
    output logic                  o_sump_id,
    output logic                  o_sump_meta,
    output logic                  o_sump_finish,
    output logic                  o_wr_divider,
    output logic                  o_wr_count,
    output logic                  o_wr_flags,
    output logic [NUM_STAGES-1:0] o_wr_trig_mask,
    output logic [NUM_STAGES-1:0] o_wr_trig_value,
    output logic [NUM_STAGES-1:0] o_wr_trig_cfg
);

    logic [7:0]            w_single;
    logic [NUM_STAGES-1:0] w_tmask;
    logic [NUM_STAGES-1:0] w_tval;
    logic [NUM_STAGES-1:0] w_tcfg;
    logic [7:0]            w_trig_base;

    assign w_trig_base = i_opcode & TRIG_BASE_MASK;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_single = '0;
        w_tmask  = '0;
        w_tval   = '0;
        w_tcfg   = '0;
        if (i_valid) begin
            case (i_opcode)
                OP_RESET:  w_single[0] = 1'b1;
                OP_RUN:    w_single[1] = 1'b1;
                OP_ID:     w_single[2] = 1'b1;
                OP_META:   w_single[3] = 1'b1;
                OP_FINISH: w_single[4] = 1'b1;
                OP_DIV:    w_single[5] = 1'b1;
                OP_CNT:    w_single[6] = 1'b1;
                OP_FLAGS:  w_single[7] = 1'b1;
                default:   w_single = '0;
            endcase
            // Loop over implemented stages only, so an out-of-range stage
            // index simply matches nothing.
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (i_opcode[4:2] == 3'(s)) begin
                    w_tmask[s] = (w_trig_base == OP_TMASK);
                    w_tval[s]  = (w_trig_base == OP_TVAL);
                    w_tcfg[s]  = (w_trig_base == OP_TCFG);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its inputs from the same clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            o_cmd_valid     <= 1'b0;
            {o_wr_flags, o_wr_count, o_wr_divider, o_sump_finish,
             o_sump_meta, o_sump_id, o_sump_run, o_sump_reset} <= '0;
            o_wr_trig_mask  <= '0;
            o_wr_trig_value <= '0;
            o_wr_trig_cfg   <= '0;
        end else begin
            o_cmd_valid     <= i_valid;
            {o_wr_flags, o_wr_count, o_wr_divider, o_sump_finish,
             o_sump_meta, o_sump_id, o_sump_run, o_sump_reset} <= w_single;
            o_wr_trig_mask  <= w_tmask;
            o_wr_trig_value <= w_tval;
            o_wr_trig_cfg   <= w_tcfg;
        end
    end

endmodule

// File: rtl/sump_cmd_decoder.sv
// SUMP command decoder: assembles short (1-byte) and long (opcode + ARG_BYTES
// argument bytes, LSB first) commands from the UART byte stream.
//   clock, reset          : system clock, synchronous active-high reset
//   rx_data, rx_valid     : received byte and its one-cycle valid
//   cmd_valid             : pulse for any complete command
//   cmd_opcode, cmd_arg   : last complete command's opcode / argument (held)
//   sump_* / wr_*         : decoded one-cycle strobes
//   busy                  : collecting argument bytes
//   abort                 : pulse when a partial long command times out
module sump_cmd_decoder
    import sump_pkg::*;
#(
    parameter int ARG_BYTES   = 4,
    parameter int NUM_STAGES  = 4,
    parameter int TIMEOUT_CYC = 65535,
    parameter int TW          = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   cmd_valid,
    output logic [7:0]             cmd_opcode,
    output logic [8*ARG_BYTES-1:0] cmd_arg,
    output logic                   sump_reset,
    output logic                   sump_run,
    output logic                   sump_id,
    output logic                   sump_meta,
    output logic                   sump_finish,
    output logic                   wr_divider,
    output logic                   wr_count,
    output logic                   wr_flags,
    output logic [NUM_STAGES-1:0]  wr_trig_mask,
    output logic [NUM_STAGES-1:0]  wr_trig_value,
    output logic [NUM_STAGES-1:0]  wr_trig_cfg,
    output logic                   busy,
    output logic                   abort
);

    localparam int             CW        = $clog2(ARG_BYTES + 1);
    localparam logic [CW-1:0]  LAST_BYTE = CW'(ARG_BYTES - 1);
    localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYC - 1);

    state_t                 r_state;
    logic [CW-1:0]          r_count;
    logic [TW-1:0]          r_timer;
    logic [7:0]             r_long_op;
    logic [8*ARG_BYTES-1:0] r_shadow;
    logic [8*ARG_BYTES-1:0] r_arg;
    logic [7:0]             r_opcode;
    logic                   r_abort;

    logic                   w_short_done;
    logic                   w_long_done;
    logic                   w_done;
    logic [7:0]             w_opcode;
    logic [8*ARG_BYTES-1:0] w_arg_next;

    assign w_short_done = (r_state == IDLE) && rx_valid && !rx_data[7];
    assign w_long_done  = (r_state == ARGS) && rx_valid && (r_count == LAST_BYTE);
    assign w_done       = w_short_done || w_long_done;
    assign w_opcode     = (r_state == ARGS) ? r_long_op : rx_data;

    // The final argument byte goes straight into the published word so the
    // command completes one clock after it arrives.
    always_comb begin
        w_arg_next = r_shadow;
        w_arg_next[8*(ARG_BYTES-1) +: 8] = rx_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_timer   <= '0;
            r_long_op <= '0;
            r_shadow  <= '0;
            r_arg     <= '0;
            r_opcode  <= '0;
            r_abort   <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            if (w_done)      r_opcode <= w_opcode;
            if (w_long_done) r_arg    <= w_arg_next;

            case (r_state)
                IDLE: begin
                    if (rx_valid && rx_data[7]) begin
                        r_long_op <= rx_data;
                        r_count   <= '0;
                        r_timer   <= '0;
                        r_state   <= ARGS;
                    end
                end
                ARGS: begin
                    // Every byte here is argument data, even ones that look
                    // like short opcodes. A byte arriving on the expiry
                    // cycle wins over the timeout.
                    if (rx_valid) begin
                        for (int k = 0; k < ARG_BYTES; k++) begin
                            if (r_count == CW'(k)) r_shadow[8*k +: 8] <= rx_data;
                        end
                        r_count <= r_count + 1'b1;
                        r_timer <= '0;
                        if (r_count == LAST_BYTE) r_state <= IDLE;
                    end else if (r_timer == TO_LAST) begin
                        r_abort <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_opcode = r_opcode;
    assign cmd_arg    = r_arg;
    assign busy       = (r_state == ARGS);
    assign abort      = r_abort;

    sump_cmd_strobe #(
        .NUM_STAGES(NUM_STAGES)
    ) u_strobe (
        .clock          (clock),
        .reset          (reset),
        .i_valid        (w_done),
        .i_opcode       (w_opcode),
        .o_cmd_valid    (cmd_valid),
        .o_sump_reset   (sump_reset),
        .o_sump_run     (sump_run),
        .o_sump_id      (sump_id),
        .o_sump_meta    (sump_meta),
        .o_sump_finish  (sump_finish),
        .o_wr_divider   (wr_divider),
        .o_wr_count     (wr_count),
        .o_wr_flags     (wr_flags),
        .o_wr_trig_mask (wr_trig_mask),
        .o_wr_trig_value(wr_trig_value),
        .o_wr_trig_cfg  (wr_trig_cfg)
    );

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Directed bench for sump_cmd_decoder. Two instances share the stimulus:
// "a" with 4 trigger stages, "b" with 2; both use a 10-clock timeout.
// Inputs change on the falling edge, outputs are checked on the falling edge.
module tb_sump_cmd_decoder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;

    always #5 clock = ~clock;

    logic        a_cmd_valid, a_sump_reset, a_sump_run, a_sump_id, a_sump_meta;
    logic        a_sump_finish, a_wr_divider, a_wr_count, a_wr_flags, a_busy, a_abort;
    logic [7:0]  a_cmd_opcode;
    logic [31:0] a_cmd_arg;
    logic [3:0]  a_tm, a_tv, a_tc;

    logic        b_cmd_valid, b_sump_reset, b_sump_run, b_sump_id, b_sump_meta;
    logic        b_sump_finish, b_wr_divider, b_wr_count, b_wr_flags, b_busy, b_abort;
    logic [7:0]  b_cmd_opcode;
    logic [31:0] b_cmd_arg;
    logic [1:0]  b_tm, b_tv, b_tc;

    sump_cmd_decoder #(.ARG_BYTES(4), .NUM_STAGES(4), .TIMEOUT_CYC(10), .TW(16)) dut_a (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_valid(a_cmd_valid), .cmd_opcode(a_cmd_opcode), .cmd_arg(a_cmd_arg),
        .sump_reset(a_sump_reset), .sump_run(a_sump_run), .sump_id(a_sump_id),
        .sump_meta(a_sump_meta), .sump_finish(a_sump_finish),
        .wr_divider(a_wr_divider), .wr_count(a_wr_count), .wr_flags(a_wr_flags),
        .wr_trig_mask(a_tm), .wr_trig_value(a_tv), .wr_trig_cfg(a_tc),
        .busy(a_busy), .abort(a_abort)
    );

    sump_cmd_decoder #(.ARG_BYTES(4), .NUM_STAGES(2), .TIMEOUT_CYC(10), .TW(16)) dut_b (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_valid(b_cmd_valid), .cmd_opcode(b_cmd_opcode), .cmd_arg(b_cmd_arg),
        .sump_reset(b_sump_reset), .sump_run(b_sump_run), .sump_id(b_sump_id),
        .sump_meta(b_sump_meta), .sump_finish(b_sump_finish),
        .wr_divider(b_wr_divider), .wr_count(b_wr_count), .wr_flags(b_wr_flags),
        .wr_trig_mask(b_tm), .wr_trig_value(b_tv), .wr_trig_cfg(b_tc),
        .busy(b_busy), .abort(b_abort)
    );

    // Packed view: [22]cmd_valid [21:17]reset,run,id,meta,finish
    // [16:14]divider,count,flags [13:10]tmask [9:6]tvalue [5:2]tcfg [1]abort [0]busy
    logic [22:0] obs_a, obs_b;
    assign obs_a = {a_cmd_valid, a_sump_reset, a_sump_run, a_sump_id, a_sump_meta,
                    a_sump_finish, a_wr_divider, a_wr_count, a_wr_flags,
                    a_tm, a_tv, a_tc, a_abort, a_busy};
    assign obs_b = {b_cmd_valid, b_sump_reset, b_sump_run, b_sump_id, b_sump_meta,
                    b_sump_finish, b_wr_divider, b_wr_count, b_wr_flags,
                    2'b00, b_tm, 2'b00, b_tv, 2'b00, b_tc, b_abort, b_busy};

    // Instance b has only stages 0 and 1: stage 2/3 bits never appear.
    localparam logic [22:0] MASK_B = ~23'h003330;
    localparam logic [22:0] BUSY   = 23'h000001;

    int tests = 0;
    int fails = 0;

    function automatic logic [22:0] ev(input logic cv, input logic [4:0] sh,
                                       input logic [2:0] lg, input logic [3:0] tm,
                                       input logic [3:0] tv, input logic [3:0] tc,
                                       input logic ab, input logic bz);
        return {cv, sh, lg, tm, tv, tc, ab, bz};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [22:0] e);
        chk({tag, "/a.strobes"}, 64'(obs_a), 64'(e));
        chk({tag, "/b.strobes"}, 64'(obs_b), 64'(e & MASK_B));
    endtask

    task automatic chk_out(input string tag, input logic [7:0] op, input logic [31:0] arg);
        chk({tag, "/a.opcode"}, 64'(a_cmd_opcode), 64'(op));
        chk({tag, "/a.arg"},    64'(a_cmd_arg),    64'(arg));
        chk({tag, "/b.opcode"}, 64'(b_cmd_opcode), 64'(op));
        chk({tag, "/b.arg"},    64'(b_cmd_arg),    64'(arg));
    endtask

    // Called at a falling edge; returns at the next falling edge, after the
    // byte has been captured, so registered results are visible on return.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Long command; busy alone must be high between bytes (embedded zeros
    // and short-opcode-looking bytes must not fire strobes).
    task automatic long_cmd(input string tag, input logic [7:0] op, input logic [31:0] arg);
        send(op);
        chk_vec({tag, ".op"}, BUSY);
        for (int i = 0; i < 3; i++) begin
            send(arg[8*i +: 8]);
            chk_vec({tag, ".arg"}, BUSY);
        end
        send(arg[31:24]);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk_vec("reset", '0);
        chk_out("reset", 8'h00, 32'h0);
        reset = 1'b0;
        idle(1);

        // Short commands, one strobe per byte
        send(8'h00); chk_vec("s00", ev(1, 5'b10000, 0, 0, 0, 0, 0, 0)); chk_out("s00", 8'h00, 32'h0);
        send(8'h01); chk_vec("s01", ev(1, 5'b01000, 0, 0, 0, 0, 0, 0));
        send(8'h02); chk_vec("s02", ev(1, 5'b00100, 0, 0, 0, 0, 0, 0));
        send(8'h04); chk_vec("s04", ev(1, 5'b00010, 0, 0, 0, 0, 0, 0));
        send(8'h05); chk_vec("s05", ev(1, 5'b00001, 0, 0, 0, 0, 0, 0)); chk_out("s05", 8'h05, 32'h0);
        idle(1);     chk_vec("pulse_end", '0);
        send(8'h03); chk_vec("s03_unknown", ev(1, 0, 0, 0, 0, 0, 0, 0)); chk_out("s03", 8'h03, 32'h0);

        // Long commands
        long_cmd("tmask0", 8'hC0, 32'h000000FF);
        chk_vec("tmask0", ev(1, 0, 0, 4'b0001, 0, 0, 0, 0)); chk_out("tmask0", 8'hC0, 32'h000000FF);
        long_cmd("flags", 8'h82, 32'h00000800);
        chk_vec("flags", ev(1, 0, 3'b001, 0, 0, 0, 0, 0)); chk_out("flags", 8'h82, 32'h00000800);
        long_cmd("count", 8'h81, 32'h000F000F);
        chk_vec("count", ev(1, 0, 3'b010, 0, 0, 0, 0, 0)); chk_out("count", 8'h81, 32'h000F000F);

        // Stage decode (b sees stages 2/3 as cmd_valid only)
        long_cmd("tcfg3", 8'hCE, 32'h04030201);
        chk_vec("tcfg3", ev(1, 0, 0, 0, 0, 4'b1000, 0, 0)); chk_out("tcfg3", 8'hCE, 32'h04030201);
        long_cmd("tval3", 8'hCD, 32'h11111111);
        chk_vec("tval3", ev(1, 0, 0, 0, 4'b1000, 0, 0, 0));
        long_cmd("tval2", 8'hC9, 32'h22222222);
        chk_vec("tval2", ev(1, 0, 0, 0, 4'b0100, 0, 0, 0));
        long_cmd("tval1", 8'hC5, 32'h33333333);
        chk_vec("tval1", ev(1, 0, 0, 0, 4'b0010, 0, 0, 0));

        // Embedded zeros and an unknown long opcode
        long_cmd("div0", 8'h80, 32'h00000000);
        chk_vec("div0", ev(1, 0, 3'b100, 0, 0, 0, 0, 0)); chk_out("div0", 8'h80, 32'h0);
        long_cmd("l83", 8'h83, 32'hDDCCBBAA);
        chk_vec("l83_unknown", ev(1, 0, 0, 0, 0, 0, 0, 0)); chk_out("l83", 8'h83, 32'hDDCCBBAA);

        // Timeout after a truncated command
        send(8'hC1); send(8'h12); send(8'h34);
        idle(9);     chk_vec("to_before", BUSY);
        idle(1);     chk_vec("to_abort", ev(0, 0, 0, 0, 0, 0, 1, 0)); chk_out("to_abort", 8'h83, 32'hDDCCBBAA);
        idle(1);     chk_vec("to_after", '0);
        send(8'h02); chk_vec("to_id", ev(1, 5'b00100, 0, 0, 0, 0, 0, 0)); chk_out("to_id", 8'h02, 32'hDDCCBBAA);

        // Byte arriving on the expiry cycle wins
        send(8'hC1); send(8'h11); send(8'h22); send(8'h33);
        idle(9);
        send(8'h44); chk_vec("byte_wins", ev(1, 0, 0, 0, 4'b0001, 0, 0, 0)); chk_out("byte_wins", 8'hC1, 32'h44332211);

        // Back-to-back with a short command right behind the long one
        send(8'h81); send(8'h04); send(8'h00); send(8'h04); send(8'h00);
        chk_vec("b2b_count", ev(1, 0, 3'b010, 0, 0, 0, 0, 0)); chk_out("b2b_count", 8'h81, 32'h00040004);
        send(8'h01);
        chk_vec("b2b_run", ev(1, 5'b01000, 0, 0, 0, 0, 0, 0)); chk_out("b2b_run", 8'h01, 32'h00040004);

        // Reset in the middle of a long command
        send(8'hC2); send(8'hAA); send(8'hBB);
        reset = 1'b1;
        idle(1);     chk_vec("mid_reset", '0); chk_out("mid_reset", 8'h00, 32'h0);
        reset = 1'b0;
        idle(12);    chk_vec("mid_reset_no_abort", '0);
        send(8'h02); chk_vec("post_reset_id", ev(1, 5'b00100, 0, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sump_cmd_decoder.md
Name: sump_cmd_decoder

Overview:
- Parametrised successor to the fixed SUMP command decoder in the logic sniffer core.
- Consumes the UART receive byte stream and assembles short (1-byte) and long (opcode + ARG_BYTES argument bytes, LSB first) commands.
- Emits one-cycle decoded strobes plus a held argument word to the sampler, trigger and controller blocks.
- Generalised over trigger stage count and argument width. Adds an inter-byte timeout that resynchronises after a truncated long command, plus an error/abort indication.

Parameters:
- ARG_BYTES, 4, argument bytes per long command (1..8).
- NUM_STAGES, 4, trigger stages decoded (1..8); stage index is opcode bits [4:2].
- TIMEOUT_CYC, 65535, max idle clocks between bytes of one long command (must be >= 1).
- TW, 16, timeout counter width; must satisfy 2**TW > TIMEOUT_CYC.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid this cycle (single-cycle pulse per byte).
- cmd_valid  out  1  one-cycle pulse: any complete command decoded.
- cmd_opcode  out  8  opcode of last complete command; held.
- cmd_arg  out  8*ARG_BYTES  argument of last long command; held.
- sump_reset  out  1  pulse, opcode 0x00.
- sump_run  out  1  pulse, opcode 0x01.
- sump_id  out  1  pulse, opcode 0x02.
- sump_meta  out  1  pulse, opcode 0x04.
- sump_finish  out  1  pulse, opcode 0x05 (RLE finish).
- wr_divider  out  1  pulse, opcode 0x80.
- wr_count  out  1  pulse, opcode 0x81.
- wr_flags  out  1  pulse, opcode 0x82.
- wr_trig_mask  out  NUM_STAGES  one-hot pulse, opcode 0xC0|(s<<2).
- wr_trig_value  out  NUM_STAGES  one-hot pulse, opcode 0xC1|(s<<2).
- wr_trig_cfg  out  NUM_STAGES  one-hot pulse, opcode 0xC2|(s<<2).
- busy  out  1  high while collecting argument bytes.
- abort  out  1  one-cycle pulse when a partial long command is discarded.

Behaviour:
- Reset: all outputs 0; cmd_opcode=0, cmd_arg=0; FSM=IDLE; byte and timeout counters cleared.
- FSM states IDLE and ARGS.
- IDLE, rx_valid with rx_data[7]=0 (short command):
  - Next cycle: cmd_valid=1, cmd_opcode=byte, matching short strobe=1.
  - Unknown short opcodes pulse cmd_valid only.
  - Latency 1 clock.
- IDLE, rx_valid with rx_data[7]=1 (long command): latch opcode, clear byte count and timeout, go to ARGS, busy=1.
- ARGS, rx_valid:
  - Store the byte at cmd_arg slot [8*k +: 8], k = byte count, in a shadow register. cmd_arg is updated only on completion.
  - Increment count, reset timeout.
  - When count reaches ARG_BYTES: next cycle cmd_valid=1, cmd_opcode and cmd_arg updated, matching long strobe=1, FSM=IDLE, busy=0.
  - Latency 1 clock after the last byte.
- In ARGS, every byte is data, including 0x00; a short opcode does not interrupt.
- ARGS with no rx_valid: timeout counter increments. On reaching TIMEOUT_CYC:
  - abort pulse next cycle.
  - FSM=IDLE, shadow discarded, cmd_* unchanged, no strobes.
- rx_valid on the same cycle the timeout expires: the byte is accepted and the timeout is cleared (byte wins).
- Trigger opcodes with stage index s >= NUM_STAGES: cmd_valid only, no wr_trig_* bit.
- Unknown long opcodes: cmd_valid only.
- At most one decoded strobe is high per cycle; every strobe coincides with cmd_valid.
- Back-to-back rx_valid on consecutive clocks is fully supported with no lost bytes. A new opcode byte may arrive on the cycle the previous command's strobes fire.
- Reset mid-ARGS: partial command dropped, no abort pulse, outputs as at reset.
- The sump_reset strobe does not reset this block; it is an output only.

Decomposition:
- Package sump_pkg:
  - opcode localparams: OP_RESET=8'h00, OP_RUN=8'h01, OP_ID=8'h02, OP_META=8'h04, OP_FINISH=8'h05, OP_DIV=8'h80, OP_CNT=8'h81, OP_FLAGS=8'h82, OP_TMASK=8'hC0, OP_TVAL=8'hC1, OP_TCFG=8'hC2.
  - state enum {IDLE, ARGS}.
- One sub-module is natural: sump_cmd_strobe. It is a registered opcode-to-strobe decoder parametrised by NUM_STAGES. Assembly FSM and timeout live in the top.

Test Plan:
- Short commands: bytes 00,01,02,04,05 -> one sump_reset, sump_run, sump_id, sump_meta, sump_finish pulse each, 1 clock after each byte; cmd_valid with each.
- Long command: C0 FF 00 00 00 -> wr_trig_mask=4'b0001, cmd_arg=32'h000000FF. Then 82 00 08 00 00 -> wr_flags, cmd_arg=32'h00000800. Then 81 0F 00 0F 00 -> wr_count, cmd_arg=32'h000F000F.
- Stage decode with NUM_STAGES=4: CE, CD, C9 with 4-byte args -> wr_trig_cfg=4'b1000, wr_trig_value=4'b1000, wr_trig_value=4'b0100. Repeat with NUM_STAGES=2: CE -> cmd_valid only.
- Embedded zero bytes: 80 00 00 00 00 -> wr_divider with cmd_arg=0; no sump_reset pulses.
- Timeout, with TIMEOUT_CYC=10: C1 12 34, then 10 idle clocks -> abort pulse, no cmd_valid, cmd_arg unchanged. Then 02 -> sump_id.
- Back-to-back bytes on consecutive clocks: 81 04 00 04 00 01 -> wr_count with cmd_arg=32'h00040004, then sump_run. Also assert reset mid-ARGS -> no strobes, cmd_arg=0.
